// File: rtl/sqrt_floor_seq_if.sv
// Start/busy/done handshake bundle for the sequential floor square root.
// The producer side drives the request; the root unit drives status and results.
interface sqrt_floor_seq_if #(
  parameter int WIDTH = 8
);
  localparam int N = WIDTH / 2;

  logic             start;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             done;
  logic [N-1:0]     root;
  logic [N:0]       rem;

  modport master (
    output start,
    output x,
    input  busy,
    input  done,
    input  root,
    input  rem
  );

  modport slave (
    input  start,
    input  x,
    output busy,
    output done,
    output root,
    output rem
  );
endinterface

// File: rtl/sqrt_floor_seq.sv
// Sequential integer square root: root = floor(sqrt(x)), rem = x - root^2.
// Restoring digit-by-digit method, one root bit resolved per clock.
module sqrt_floor_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  sqrt_floor_seq_if.slave  bus
);
  localparam int N  = WIDTH / 2;
  localparam int TW = N + 3;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N:0]   r;
  } step_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [N-1:0]     q_q, q_d;
  logic [N:0]       r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     root_q, root_d;
  logic [N:0]       rem_q, rem_d;
  step_t            step;

  // One restoring iteration. The trial value is kept at full N+3 bits so the
  // compare sees every bit; the new remainder is bounded by 2*q and fits N+1.
  function automatic step_t sqrt_step(input logic [N-1:0] q,
                                      input logic [N:0]   r,
                                      input logic [1:0]   p);
    logic [TW-1:0] t;
    logic [TW-1:0] d;
    logic [TW-1:0] diff;
    step_t         s;
    t    = {r, p};
    d    = {1'b0, q, 2'b01};
    diff = t - d;
    if (t >= d) begin
      s.r = diff[N:0];
      s.q = (q << 1) | N'(1);
    end else begin
      s.r = t[N:0];
      s.q = q << 1;
    end
    return s;
  endfunction

  // The operand is shifted left two bits per iteration, so the current pair
  // is always its top two bits.
  assign step = sqrt_step(q_q, r_q, xs_q[WIDTH-1 -: 2]);

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          xs_d    = bus.x;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = CW'(N);
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        q_d   = step.q;
        r_d   = step.r;
        xs_d  = xs_q << 2;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          root_d  = step.q;
          rem_d   = step.r;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xs_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.busy = (state_q == CALC);
  assign bus.done = (state_q == DONE);
  assign bus.root = root_q;
  assign bus.rem  = rem_q;

endmodule

// File: tb/tb_sqrt_floor_seq.sv
// Self-checking bench for sqrt_floor_seq at WIDTH=8 and WIDTH=6 against an
// arithmetic floor-sqrt model.
module tb_sqrt_floor_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sqrt_floor_seq_if #(.WIDTH(8)) if8 ();
  sqrt_floor_seq_if #(.WIDTH(6)) if6 ();

  sqrt_floor_seq #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  sqrt_floor_seq #(.WIDTH(6)) u6 (.clk(clk), .rst_n(rst_n), .bus(if6.slave));

  function automatic int model_root(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Drives one request on the WIDTH=8 unit and waits (bounded) for done.
  task automatic run_w8(input int val, output int r, output int m,
                        output int nbusy, output int ncyc, output bit ok,
                        output bit overlap);
    @(negedge clk);
    if8.start = 1'b1;
    if8.x     = 8'(val);
    nbusy = 0; ncyc = 0; ok = 1'b0; overlap = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if8.start = 1'b0;
      if8.x     = 8'($urandom);
      if (if8.busy && if8.done) overlap = 1'b1;
      if (if8.done) begin
        ok = 1'b1; ncyc = c;
        break;
      end
      if (if8.busy) nbusy++;
    end
    r = int'(if8.root);
    m = int'(if8.rem);
  endtask

  task automatic run_w6(input int val, output int r, output int m,
                        output int nbusy, output bit ok);
    @(negedge clk);
    if6.start = 1'b1;
    if6.x     = 6'(val);
    nbusy = 0; ok = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if6.start = 1'b0;
      if6.x     = 6'($urandom);
      if (if6.done) begin
        ok = 1'b1;
        break;
      end
      if (if6.busy) nbusy++;
    end
    r = int'(if6.root);
    m = int'(if6.rem);
  endtask

  task automatic wait_done8(output int cyc, output bit ok);
    ok = 1'b0; cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if8.done) begin
        ok = 1'b1; cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    if8.start = 1'b0; if8.x = '0;
    if6.start = 1'b0; if6.x = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({if8.busy, if8.done, if8.root, if8.rem} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b root=%0d rem=%0d, want all 0",
               if8.busy, if8.done, if8.root, if8.rem);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", if8.busy, if8.done);
    end
  endtask

  task automatic test_directed();
    int vals[4] = '{0, 255, 25, 24};
    int r, m, nb, nc; bit ok, ov;
    foreach (vals[k]) begin
      run_w8(vals[k], r, m, nb, nc, ok, ov);
      n_tests++;
      if (!ok || r !== model_root(vals[k]) || m !== vals[k] - model_root(vals[k]) ** 2) begin
        n_fail++;
        $display("FAIL directed x=%0d: got done=%b root=%0d rem=%0d, want root=%0d rem=%0d",
                 vals[k], ok, r, m, model_root(vals[k]), vals[k] - model_root(vals[k]) ** 2);
      end
      // done follows the accepting edge by exactly N=4 edges
      n_tests++;
      if (nc !== 5 || nb !== 4) begin
        n_fail++;
        $display("FAIL latency x=%0d: got done at negedge %0d after %0d busy, want 5 after 4",
                 vals[k], nc, nb);
      end
    end
  endtask

  task automatic test_exhaustive();
    int r, m, nb, nc; bit ok, ov;
    for (int v = 0; v < 256; v++) begin
      run_w8(v, r, m, nb, nc, ok, ov);
      n_tests++;
      if (!ok || ov || nb !== 4 || r !== model_root(v) || m !== v - model_root(v) ** 2) begin
        n_fail++;
        $display("FAIL exh8 x=%0d: got ok=%b overlap=%b busy=%0d root=%0d rem=%0d, want busy=4 root=%0d rem=%0d",
                 v, ok, ov, nb, r, m, model_root(v), v - model_root(v) ** 2);
      end
      if (v % 16 == 0) begin
        @(negedge clk);
        n_tests++;
        if (if8.done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_width x=%0d: got done=%b one cycle later, want 0", v, if8.done);
        end
      end
    end
    for (int v = 0; v < 64; v++) begin
      run_w6(v, r, m, nb, ok);
      n_tests++;
      if (!ok || nb !== 3 || r !== model_root(v) || m !== v - model_root(v) ** 2) begin
        n_fail++;
        $display("FAIL exh6 x=%0d: got ok=%b busy=%0d root=%0d rem=%0d, want busy=3 root=%0d rem=%0d",
                 v, ok, nb, r, m, model_root(v), v - model_root(v) ** 2);
      end
    end
  endtask

  task automatic test_ignore_busy_start();
    int cyc; bit ok;
    int prev_root, prev_rem;
    prev_root = int'(if8.root);
    prev_rem  = int'(if8.rem);
    @(negedge clk);
    if8.start = 1'b1; if8.x = 8'd200;
    @(negedge clk);
    if8.start = 1'b0; if8.x = 8'd0;
    @(negedge clk);
    if8.start = 1'b1; if8.x = 8'd9;
    n_tests++;
    if (int'(if8.root) !== prev_root || int'(if8.rem) !== prev_rem || if8.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_during_calc: got busy=%b root=%0d rem=%0d, want busy=1 root=%0d rem=%0d",
               if8.busy, if8.root, if8.rem, prev_root, prev_rem);
    end
    @(negedge clk);
    if8.start = 1'b0;
    wait_done8(cyc, ok);
    n_tests++;
    if (!ok || if8.root !== 4'd14 || if8.rem !== 5'd4) begin
      n_fail++;
      $display("FAIL ignore_start: got done=%b root=%0d rem=%0d, want root=14 rem=4",
               ok, if8.root, if8.rem);
    end
    @(negedge clk);
    n_tests++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
      n_fail++;
      $display("FAIL no_queued_op: got busy=%b done=%b, want 0 0", if8.busy, if8.done);
    end
  endtask

  task automatic test_back_to_back();
    int r, m, nb, nc, cyc; bit ok, ov;
    run_w8(100, r, m, nb, nc, ok, ov);
    n_tests++;
    if (!ok || r !== 10 || m !== 0) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b root=%0d rem=%0d, want root=10 rem=0", ok, r, m);
    end
    if8.start = 1'b1; if8.x = 8'd50;
    @(negedge clk);
    if8.start = 1'b0; if8.x = 8'd0;
    n_tests++;
    if (if8.busy !== 1'b1 || if8.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy: got busy=%b done=%b, want 1 0", if8.busy, if8.done);
    end
    wait_done8(cyc, ok);
    n_tests++;
    if (!ok || cyc !== 4 || if8.root !== 4'd7 || if8.rem !== 5'd1) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b cyc=%0d root=%0d rem=%0d, want cyc=4 root=7 rem=1",
               ok, cyc, if8.root, if8.rem);
    end
  endtask

  task automatic test_reset_abort();
    int r, m, nb, nc; bit ok, ov;
    bit saw_done = 1'b0;
    @(negedge clk);
    if8.start = 1'b1; if8.x = 8'd255;
    @(negedge clk);
    if8.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if8.busy, if8.done, if8.root, if8.rem} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_abort: got busy=%b done=%b root=%0d rem=%0d, want all 0",
               if8.busy, if8.done, if8.root, if8.rem);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if8.done || if8.busy) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got activity=%b after reset, want 0", saw_done);
    end
    run_w8(16, r, m, nb, nc, ok, ov);
    n_tests++;
    if (!ok || r !== 4 || m !== 0) begin
      n_fail++;
      $display("FAIL after_reset x=16: got done=%b root=%0d rem=%0d, want root=4 rem=0", ok, r, m);
    end
  endtask

  task automatic test_random();
    int r, m, nb, nc; bit ok, ov;
    for (int k = 0; k < 40; k++) begin
      int v;
      v = int'($urandom_range(255, 0));
      run_w8(v, r, m, nb, nc, ok, ov);
      n_tests++;
      if (!ok || r !== model_root(v) || m !== v - model_root(v) ** 2) begin
        n_fail++;
        $display("FAIL random x=%0d: got done=%b root=%0d rem=%0d, want root=%0d rem=%0d",
                 v, ok, r, m, model_root(v), v - model_root(v) ** 2);
      end
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_exhaustive();
    test_ignore_busy_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
